professor_scheduler: RTL and testbench



---
 rtl/professor_scheduler.sv | 151 +++++++++++++++
 tb/tb_professor_scheduler.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/professor_scheduler.sv
// Professor visit scheduler: sends a Warn lead-in, then raises Professor after a
// pseudo-random number of game seconds, and holds it until the quiz logic completes
// a 4-phase Quiz_Done handshake. It also keeps saturating visit and fail counters.
`timescale 1ns/1ps

module professor_scheduler #(
    parameter int unsigned TICK_DIV       = 100000000,
    parameter int unsigned MIN_GAP        = 8,
    parameter int unsigned GAP_RANGE_LOG2 = 3,
    parameter int unsigned WARN_SECS      = 2,
    parameter logic [15:0] LFSR_SEED      = 16'hACE1
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic       Enable,
    input  logic       Quiz_Done,
    input  logic       Quiz_Pass,
    output logic       Warn,
    output logic       Professor,
    output logic       Sec_Tick,
    output logic [3:0] Visits,
    output logic [2:0] Fails
);

    localparam int unsigned PW       = $clog2(TICK_DIV);
    localparam logic [PW-1:0] PrescMax = PW'(TICK_DIV - 1);
    localparam logic [7:0]    WarnAt   = 8'(WARN_SECS);

    typedef enum logic [2:0] {
        StOff,
        StWait,
        StWarn,
        StPresent,
        StRelease
    } state_e;

    state_e         state_q;
    logic [PW-1:0]  presc_q;
    logic [7:0]     gap_q;
    logic [15:0]    lfsr_q;
    logic           warn_q;
    logic           prof_q;
    logic           sec_tick_q;
    logic [3:0]     visits_q;
    logic [2:0]     fails_q;

    logic           counting;
    logic           tick_d;
    logic [7:0]     gap_load_d;
    logic [7:0]     gap_dec;
    logic [15:0]    lfsr_d;

    // Prescaler wrap detect, next gap, next LFSR value and decremented gap.
    always_comb begin
        counting   = (state_q == StWait) || (state_q == StWarn);
        tick_d     = counting && (presc_q == PrescMax);
        gap_load_d = 8'(MIN_GAP) + 8'(lfsr_q[GAP_RANGE_LOG2-1:0]);
        lfsr_d     = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? 16'hB400 : 16'h0000);
        gap_dec    = gap_q - 8'd1;
    end

    // Scheduler FSM with registered outputs, prescaler, LFSR and counters.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q    <= StOff;
            presc_q    <= '0;
            gap_q      <= '0;
            lfsr_q     <= LFSR_SEED;
            warn_q     <= 1'b0;
            prof_q     <= 1'b0;
            sec_tick_q <= 1'b0;
            visits_q   <= '0;
            fails_q    <= '0;
        end else begin
            sec_tick_q <= tick_d;
            if (counting) begin
                presc_q <= tick_d ? '0 : presc_q + PW'(1);
            end

            case (state_q)
                StOff: begin
                    warn_q  <= 1'b0;
                    prof_q  <= 1'b0;
                    presc_q <= '0;
                    if (Enable) begin
                        gap_q   <= gap_load_d;
                        lfsr_q  <= lfsr_d;
                        state_q <= StWait;
                    end
                end
                StWait: begin
                    if (!Enable) begin
                        state_q <= StOff;
                    end else if (tick_d) begin
                        gap_q <= gap_dec;
                        if (gap_dec == WarnAt) begin
                            warn_q  <= 1'b1;
                            state_q <= StWarn;
                        end
                    end
                end
                StWarn: begin
                    if (!Enable) begin
                        warn_q  <= 1'b0;
                        state_q <= StOff;
                    end else if (tick_d) begin
                        gap_q <= gap_dec;
                        if (gap_dec == 8'd0) begin
                            warn_q  <= 1'b0;
                            prof_q  <= 1'b1;
                            state_q <= StPresent;
                        end
                    end
                end
                StPresent: begin
                    // Enable is ignored here: a visit in progress always completes.
                    if (Quiz_Done) begin
                        prof_q <= 1'b0;
                        if (visits_q != 4'hF) begin
                            visits_q <= visits_q + 4'd1;
                        end
                        if (!Quiz_Pass && (fails_q != 3'h7)) begin
                            fails_q <= fails_q + 3'd1;
                        end
                        state_q <= StRelease;
                    end
                end
                StRelease: begin
                    if (!Quiz_Done) begin
                        if (Enable) begin
                            gap_q   <= gap_load_d;
                            lfsr_q  <= lfsr_d;
                            presc_q <= '0;
                            state_q <= StWait;
                        end else begin
                            state_q <= StOff;
                        end
                    end
                end
                default: state_q <= StOff;
            endcase
        end
    end

    assign Warn      = warn_q;
    assign Professor = prof_q;
    assign Sec_Tick  = sec_tick_q;
    assign Visits    = visits_q;
    assign Fails     = fails_q;

endmodule

// File: tb/tb_professor_scheduler.sv
// Bench for professor_scheduler: expected output events (Sec_Tick pulses, Warn and
// Professor edges) are queued with their cycle when stimulus is driven. A monitor
// pops and compares them as the DUT produces them. Counters are checked directly.
`timescale 1ns/1ps

module tb_professor_scheduler;

    localparam int unsigned TD   = 4;
    localparam int unsigned MG   = 3;
    localparam int unsigned GRL  = 2;
    localparam int unsigned WS   = 1;
    localparam logic [15:0] SEED = 16'hACE1;
    localparam int          FAR  = 1000000;

    localparam int EvTick     = 1;
    localparam int EvWarnRise = 2;
    localparam int EvWarnFall = 3;
    localparam int EvProfRise = 4;
    localparam int EvProfFall = 5;

    typedef struct {
        int code;
        int cyc;
    } ev_t;

    logic       Clk;
    logic       Reset;
    logic       Enable;
    logic       Quiz_Done;
    logic       Quiz_Pass;
    logic       Warn;
    logic       Professor;
    logic       Sec_Tick;
    logic [3:0] Visits;
    logic [2:0] Fails;

    int          n_checks;
    int          n_errors;
    int          cyc;
    ev_t         exp_q[$];
    logic [15:0] lfsr_m;
    int          exp_v;
    int          exp_f;
    logic        warn_p;
    logic        prof_p;

    professor_scheduler #(
        .TICK_DIV      (TD),
        .MIN_GAP       (MG),
        .GAP_RANGE_LOG2(GRL),
        .WARN_SECS     (WS),
        .LFSR_SEED     (SEED)
    ) u_dut (
        .Clk      (Clk),
        .Reset    (Reset),
        .Enable   (Enable),
        .Quiz_Done(Quiz_Done),
        .Quiz_Pass(Quiz_Pass),
        .Warn     (Warn),
        .Professor(Professor),
        .Sec_Tick (Sec_Tick),
        .Visits   (Visits),
        .Fails    (Fails)
    );

    initial begin
        Clk = 1'b0;
        forever #5 Clk = ~Clk;
    end

    initial begin
        cyc = 0;
        forever begin
            @(posedge Clk);
            cyc++;
        end
    end

    task automatic check_eq(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge Clk);
    endtask

    task automatic push_ev(input int code, input int c);
        ev_t e;
        e.code = code;
        e.cyc  = c;
        exp_q.push_back(e);
    endtask

    // Events of one visit starting with WAIT entry at edge w, limited to cycles < limit.
    task automatic push_visit(input int w, input int g, input int limit);
        for (int k = 1; k <= g; k++) begin
            int c;
            c = w + TD * k;
            if (c < limit) begin
                push_ev(EvTick, c);
                if (k == g - WS) push_ev(EvWarnRise, c);
                if (k == g) begin
                    push_ev(EvWarnFall, c);
                    push_ev(EvProfRise, c);
                end
            end
        end
    endtask

    task automatic take_gap(output int g);
        g = MG + (int'(lfsr_m) % (1 << GRL));
        lfsr_m = {1'b0, lfsr_m[15:1]} ^ (lfsr_m[0] ? 16'hB400 : 16'h0000);
    endtask

    // Called at the negedge where the input causing WAIT entry has just been driven.
    task automatic start_wait();
        int g;
        take_gap(g);
        push_visit(cyc + 1, g, FAR);
    endtask

    task automatic wait_prof(input string tag);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 200 && !seen; i++) begin
            step(1);
            if (Professor === 1'b1) seen = 1'b1;
        end
        if (!seen) check_eq({tag, "_timeout"}, 0, 1);
    endtask

    task automatic quiz(input bit pass);
        Quiz_Pass = pass;
        Quiz_Done = 1'b1;
        push_ev(EvProfFall, cyc + 1);
        step(1);
        if (exp_v < 15) exp_v++;
        if (!pass && exp_f < 7) exp_f++;
        check_eq("visits", int'(Visits), exp_v);
        check_eq("fails", int'(Fails), exp_f);
    endtask

    task automatic check_reset(input string tag);
        check_eq({tag, "_warn"}, int'(Warn), 0);
        check_eq({tag, "_prof"}, int'(Professor), 0);
        check_eq({tag, "_tick"}, int'(Sec_Tick), 0);
        check_eq({tag, "_visits"}, int'(Visits), 0);
        check_eq({tag, "_fails"}, int'(Fails), 0);
    endtask

    task automatic see_ev(input int code);
        ev_t e;
        if (exp_q.size() == 0) begin
            check_eq("unexpected_event", code, 0);
        end else begin
            e = exp_q.pop_front();
            check_eq($sformatf("event_code@%0d", e.cyc), code, e.code);
            check_eq($sformatf("event_cycle(code %0d)", e.code), cyc, e.cyc);
        end
    endtask

    // Output monitor: turns observed pulses and edges into events for the scoreboard.
    initial begin
        warn_p = 1'b0;
        prof_p = 1'b0;
        forever begin
            @(negedge Clk);
            if (Sec_Tick === 1'b1) see_ev(EvTick);
            if (Warn === 1'b1 && !warn_p) see_ev(EvWarnRise);
            if (Warn === 1'b0 && warn_p) see_ev(EvWarnFall);
            if (Professor === 1'b1 && !prof_p) see_ev(EvProfRise);
            if (Professor === 1'b0 && prof_p) see_ev(EvProfFall);
            warn_p = (Warn === 1'b1);
            prof_p = (Professor === 1'b1);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish, expected finish (cycle %0d)", cyc);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int w;
        int g;
        int re;
        n_checks  = 0;
        n_errors  = 0;
        Reset     = 1'b1;
        Enable    = 1'b0;
        Quiz_Done = 1'b0;
        Quiz_Pass = 1'b0;
        lfsr_m    = SEED;
        exp_v     = 0;
        exp_f     = 0;
        step(3);
        check_reset("rst0");

        // First visit from the seed, failed quiz, Quiz_Done held long.
        Reset  = 1'b0;
        Enable = 1'b1;
        start_wait();
        wait_prof("prof1");
        quiz(1'b0);
        step(10);
        check_eq("hold_visits", int'(Visits), exp_v);
        check_eq("hold_fails", int'(Fails), exp_f);
        check_eq("hold_warn", int'(Warn), 0);
        Quiz_Done = 1'b0;
        start_wait();
        wait_prof("prof2");
        quiz(1'b1);

        // Enable dropped 6 cycles into WAIT.
        Quiz_Done = 1'b0;
        w = cyc + 1;
        take_gap(g);
        push_visit(w, g, w + 6);
        step(6);
        Enable = 1'b0;
        step(1);
        check_eq("drop_warn", int'(Warn), 0);
        check_eq("drop_prof", int'(Professor), 0);
        step(4);

        // Re-enable, then drop Enable while Professor is present.
        Enable = 1'b1;
        start_wait();
        wait_prof("prof3");
        Enable = 1'b0;
        step(5);
        check_eq("prof_hold", int'(Professor), 1);
        quiz(1'b1);
        Quiz_Done = 1'b0;
        step(8);
        check_eq("off_warn", int'(Warn), 0);
        check_eq("off_prof", int'(Professor), 0);

        // Twenty failed visits saturate both counters.
        Enable = 1'b1;
        start_wait();
        for (int i = 0; i < 20; i++) begin
            wait_prof("prof_sat");
            quiz(1'b0);
            Quiz_Done = 1'b0;
            if (i < 19) start_wait();
            else Enable = 1'b0;
        end
        check_eq("sat_visits", int'(Visits), 15);
        check_eq("sat_fails", int'(Fails), 7);
        step(3);

        // Reset while Warn is high.
        Enable = 1'b1;
        w = cyc + 1;
        take_gap(g);
        re = w + TD * (g - WS) + 2;
        push_visit(w, g, re);
        push_ev(EvWarnFall, re);
        step(re - 1 - cyc);
        check_eq("pre_rst_warn", int'(Warn), 1);
        Reset = 1'b1;
        step(1);
        lfsr_m = SEED;
        exp_v  = 0;
        exp_f  = 0;
        check_reset("rst_warn");

        // Next gap comes from the seed again; then reset mid-handshake.
        Reset = 1'b0;
        start_wait();
        wait_prof("prof_after_rst");
        quiz(1'b0);
        Reset = 1'b1;
        step(1);
        lfsr_m = SEED;
        exp_v  = 0;
        exp_f  = 0;
        check_reset("rst_release");
        Reset     = 1'b0;
        Quiz_Done = 1'b0;
        start_wait();
        wait_prof("prof_final");
        quiz(1'b1);
        Quiz_Done = 1'b0;
        Enable    = 1'b0;
        step(6);
        check_eq("events_left", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
